// File: rtl/ebi_pkg.sv
// Shared EBI definitions: FSM encoding, bank/register map and default bus timing.
// Imported by the ebi_master initiator and by the FPGA EBI responder.
package ebi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AHOLD,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } ebi_state_e;

    localparam logic [3:0]  EBI_BANK_REG   = 4'h0;
    localparam logic [3:0]  EBI_BANK_BRAM  = 4'h1;
    localparam logic [12:0] EBI_REG_DUMMY0 = 13'h0000;
    localparam logic [12:0] EBI_REG_DUMMY1 = 13'h0002;

    localparam int EBI_ADDR_CYC_DEF    = 2;
    localparam int EBI_STROBE_CYC_DEF  = 4;
    localparam int EBI_HOLD_CYC_DEF    = 1;
    localparam int EBI_IDLE_CYC_DEF    = 2;
    localparam int EBI_TIMEOUT_CYC_DEF = 64;

    function automatic int ebi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ebi_phase_timer.sv
// Loadable down-counter shared by every bus phase; done flags the last cycle of a phase.
module ebi_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - 1'b1;
    end

    assign done = (value == '0);

endmodule

// File: rtl/ebi_master.sv
// EBI bus initiator: one multiplexed A/D bus cycle per accepted request, all outputs registered.
// Optional EBI_MASTER_ARDY_EN adds ebi_ardy wait-state support with a timeout and rsp_err.
module ebi_master
    import ebi_pkg::*;
#(
    parameter int ADDR_CYC   = EBI_ADDR_CYC_DEF,
    parameter int STROBE_CYC = EBI_STROBE_CYC_DEF,
    parameter int HOLD_CYC   = EBI_HOLD_CYC_DEF,
    parameter int IDLE_CYC   = EBI_IDLE_CYC_DEF
`ifdef EBI_MASTER_ARDY_EN
    , parameter int TIMEOUT_CYC = EBI_TIMEOUT_CYC_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [16:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
`ifdef EBI_MASTER_ARDY_EN
    input  logic        ebi_ardy,
    output logic        rsp_err,
`endif
    output logic [15:0] ebi_ad_out,
    output logic        ebi_ad_oe,
    input  logic [15:0] ebi_ad_in,
    output logic        ebi_ale,
    output logic        ebi_csn,
    output logic        ebi_ren,
    output logic        ebi_wen
);

    localparam int CW = $clog2(ebi_max4(ADDR_CYC, STROBE_CYC, HOLD_CYC, IDLE_CYC)) + 1;

    ebi_state_e    state, state_nxt;
    logic          we_q, nxt_we, accept, strobe_end, tmo_hit;
    logic [15:0]   addr_q, wdata_q, nxt_addr, nxt_wdata, ad_n;
    logic          csn_n, ale_n, ren_n, wen_n, oe_n, ready_n, rspv_n;
    logic          t_load, t_done;
    logic [CW-1:0] t_val, unused_t_value;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = req_addr[0];
    assign accept          = (state == ST_IDLE) && req_valid && req_ready;

    ebi_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .value    (unused_t_value),
        .done     (t_done)
    );

`ifdef EBI_MASTER_ARDY_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Timeout counts consecutive ardy-low strobe cycles, including the minimum strobe.
    assign tmo_hit    = (state == ST_STROBE) && !ebi_ardy && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign strobe_end = (t_done && ebi_ardy) || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_STROBE && !ebi_ardy) ? tmo_cnt + 1'b1 : '0;
            rsp_err <= tmo_hit;
        end
    end
`else
    assign tmo_hit    = 1'b0;
    assign strobe_end = t_done;
`endif

    always_comb begin
        state_nxt = state;
        t_load    = 1'b0;
        t_val     = '0;
        case (state)
            ST_IDLE:    if (accept)     begin state_nxt = ST_ADDR;    t_load = 1'b1; t_val = CW'(ADDR_CYC - 1);   end
            ST_ADDR:    if (t_done)     begin state_nxt = ST_AHOLD;   t_load = 1'b1; t_val = '0;                  end
            ST_AHOLD:   if (t_done)     begin state_nxt = ST_STROBE;  t_load = 1'b1; t_val = CW'(STROBE_CYC - 1); end
            ST_STROBE:  if (strobe_end) begin state_nxt = ST_HOLD;    t_load = 1'b1; t_val = CW'(HOLD_CYC - 1);   end
            ST_HOLD:    if (t_done)     begin state_nxt = ST_RECOVER; t_load = 1'b1; t_val = CW'(IDLE_CYC - 1);   end
            ST_RECOVER: if (t_done)     begin state_nxt = ST_IDLE;                                                end
            default:                    state_nxt = ST_IDLE;
        endcase

        // Outputs are registered from the next state, so they line up with the state register.
        nxt_we    = accept ? req_we         : we_q;
        nxt_addr  = accept ? req_addr[16:1] : addr_q;
        nxt_wdata = accept ? req_wdata      : wdata_q;
        csn_n   = 1'b1;
        ale_n   = 1'b1;
        ren_n   = 1'b1;
        wen_n   = 1'b1;
        oe_n    = 1'b0;
        ad_n    = ebi_ad_out;
        ready_n = 1'b0;
        rspv_n  = 1'b0;
        case (state_nxt)
            ST_IDLE:  ready_n = 1'b1;
            ST_ADDR:  begin csn_n = 1'b0; ale_n = 1'b0; oe_n = 1'b1; ad_n = nxt_addr; end
            ST_AHOLD: begin csn_n = 1'b0; oe_n = nxt_we; ad_n = nxt_addr; end
            ST_STROBE: begin
                csn_n = 1'b0;
                if (nxt_we) begin
                    wen_n = 1'b0;
                    oe_n  = 1'b1;
                    ad_n  = nxt_wdata;
                end else begin
                    ren_n = 1'b0;
                end
            end
            ST_HOLD: begin
                csn_n  = 1'b0;
                rspv_n = (state != ST_HOLD);
                oe_n   = nxt_we && (state != ST_HOLD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ebi_csn    <= 1'b1;
            ebi_ale    <= 1'b1;
            ebi_ren    <= 1'b1;
            ebi_wen    <= 1'b1;
            ebi_ad_oe  <= 1'b0;
            ebi_ad_out <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            ebi_csn    <= csn_n;
            ebi_ale    <= ale_n;
            ebi_ren    <= ren_n;
            ebi_wen    <= wen_n;
            ebi_ad_oe  <= oe_n;
            ebi_ad_out <= ad_n;
            req_ready  <= ready_n;
            rsp_valid  <= rspv_n;
            we_q       <= nxt_we;
            addr_q     <= nxt_addr;
            wdata_q    <= nxt_wdata;
            if (state == ST_STROBE && strobe_end && !we_q && !tmo_hit)
                rsp_rdata <= ebi_ad_in;
        end
    end

endmodule

// File: tb/tb_ebi_master.sv
// Bench for ebi_master: responder model on the pins, transaction-level scoreboard, directed tests.
`timescale 1ns/1ps
module tb_ebi_master;
    import ebi_pkg::*;

    localparam int ADDR_CYC   = 2;
    localparam int STROBE_CYC = 4;
    localparam int HOLD_CYC   = 1;
    localparam int IDLE_CYC   = 2;
    // Negedge distances from the cycle a request is accepted.
    localparam int RSP_LAT  = 1 + ADDR_CYC + 1 + STROBE_CYC;
    localparam int BUSY_LAT = RSP_LAT + HOLD_CYC + IDLE_CYC;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [16:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] ebi_ad_out, ebi_ad_in;
    logic        ebi_ad_oe, ebi_ale, ebi_csn, ebi_ren, ebi_wen;
`ifdef EBI_MASTER_ARDY_EN
    logic        ebi_ardy = 1'b1;
    logic        rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    ebi_master #(
        .ADDR_CYC(ADDR_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC), .IDLE_CYC(IDLE_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef EBI_MASTER_ARDY_EN
        .ebi_ardy(ebi_ardy), .rsp_err(rsp_err),
`endif
        .ebi_ad_out(ebi_ad_out), .ebi_ad_oe(ebi_ad_oe), .ebi_ad_in(ebi_ad_in),
        .ebi_ale(ebi_ale), .ebi_csn(ebi_csn), .ebi_ren(ebi_ren), .ebi_wen(ebi_wen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pin-level responder: latches the word address on ALE, serves reads while REn is low.
    logic [15:0] lat_addr = '0;
    logic [15:0] rsp_bram [0:4095];
    initial for (int i = 0; i < 4096; i++) rsp_bram[i] = '0;

    always @(posedge clk) begin
        if (!ebi_ale) lat_addr <= ebi_ad_out;
        if (!ebi_wen && ebi_ad_oe && lat_addr[15:12] == EBI_BANK_BRAM)
            rsp_bram[lat_addr[11:0]] <= ebi_ad_out;
    end

    always_comb begin
        ebi_ad_in = 16'hDEAD;
        if (!ebi_ren) begin
            if (lat_addr[15:12] == EBI_BANK_REG)
                ebi_ad_in = ({lat_addr[11:0], 1'b0} == EBI_REG_DUMMY0) ? 16'hAAAA :
                            ({lat_addr[11:0], 1'b0} == EBI_REG_DUMMY1) ? 16'h5555 : 16'h0000;
            else if (lat_addr[15:12] == EBI_BANK_BRAM)
                ebi_ad_in = rsp_bram[lat_addr[11:0]];
            else
                ebi_ad_in = 16'h0000;
        end
    end

    // Transaction-level expectation model keyed by byte address.
    logic [15:0] exp_bram [int];

    function automatic logic [15:0] model_read(input logic [16:0] a);
        int bank, off;
        bank = int'(a >> 13);
        off  = int'(a & 17'h1FFE);
        if (bank == 0) return (off == 0) ? 16'hAAAA : (off == 2) ? 16'h5555 : 16'h0000;
        if (bank == 1) return exp_bram.exists(off) ? exp_bram[off] : 16'h0000;
        return 16'h0000;
    endfunction

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [15:0] wdata;
        int          t_acc;
    } txn_t;

    txn_t        q[$];
    txn_t        cur;
    logic [16:0] mon_addr;
    int cyc = 0, t_rsp = 0, t_busy = 0;
    bit busy = 0;
    int ale_run = 0, ren_run = 0, wen_run = 0, csn_hi = 0;
    int last_ale = 0, last_ren = 0, last_wen = 0, last_busy = 0;
    int n_acc = 0, n_rsp = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            busy    = 0;
            ale_run = 0;
            ren_run = 0;
            wen_run = 0;
        end else begin
            if (!ebi_ren || !ebi_wen) begin
                check("strobe_excl", 32'(ebi_ren | ebi_wen), 1);
                check("ale_vs_strobe", 32'(ebi_ale), 1);
                check("csn_in_strobe", 32'(ebi_csn), 0);
            end
            if (!ebi_ren) check("read_oe", 32'(ebi_ad_oe), 0);
            if (q.size() > 0) begin
                mon_addr = q[0].addr;
                if (!ebi_ale) begin
                    check("addr_oe", 32'(ebi_ad_oe), 1);
                    check("addr_val", 32'(ebi_ad_out), 32'(mon_addr[16:1]));
                end
                if (!ebi_wen) begin
                    check("wr_oe", 32'(ebi_ad_oe), 1);
                    check("wr_data", 32'(ebi_ad_out), 32'(q[0].wdata));
                end
            end

            if (!ebi_ale) ale_run++;
            else if (ale_run > 0) begin check("ale_len", ale_run, ADDR_CYC); last_ale = ale_run; ale_run = 0; end
            if (!ebi_ren) ren_run++;
            else if (ren_run > 0) begin check("ren_len", ren_run, STROBE_CYC); last_ren = ren_run; ren_run = 0; end
            if (!ebi_wen) wen_run++;
            else if (wen_run > 0) begin check("wen_len", wen_run, STROBE_CYC); last_wen = wen_run; wen_run = 0; end
            if (ebi_csn) csn_hi++;
            else begin
                if (csn_hi > 0) check("csn_gap", 32'(csn_hi >= IDLE_CYC), 1);
                csn_hi = 0;
            end

            if (busy && req_ready) begin
                check("busy_len", cyc - t_busy, BUSY_LAT);
                check("rsp_to_ready", cyc - t_rsp, HOLD_CYC + IDLE_CYC);
                last_busy = cyc - t_busy - 1;
                busy = 0;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (t=%0t)", $time);
                end else begin
                    cur   = q.pop_front();
                    t_rsp = cyc;
                    check("rsp_lat", cyc - cur.t_acc, RSP_LAT);
                    if (cur.we) begin
                        check("hold_oe", 32'(ebi_ad_oe), 1);
                        check("hold_data", 32'(ebi_ad_out), 32'(cur.wdata));
                        if (cur.addr[16:13] == 4'h1) exp_bram[int'(cur.addr & 17'h1FFE)] = cur.wdata;
                    end else begin
                        check("rdata", 32'(rsp_rdata), 32'(model_read(cur.addr)));
                    end
                end
            end
            if (req_valid && req_ready) begin
                q.push_back('{we: req_we, addr: req_addr, wdata: req_wdata, t_acc: cyc});
                busy   = 1;
                t_busy = cyc;
                n_acc++;
            end
        end
    end

    task automatic do_txn(input logic we, input logic [16:0] a, input logic [15:0] d,
                          output logic [15:0] rd);
        int n;
        @(posedge clk); #1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("ready_wait", 32'(req_ready), 1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("rsp_wait", 32'(rsp_valid), 1);
        rd = rsp_rdata;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk); #1;
    endtask

    logic [15:0] rd;
    int a0, r0, n;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csn", 32'(ebi_csn), 1);
        check("rst_ale", 32'(ebi_ale), 1);
        check("rst_ren", 32'(ebi_ren), 1);
        check("rst_wen", 32'(ebi_wen), 1);
        check("rst_oe", 32'(ebi_ad_oe), 0);
        check("rst_ad", 32'(ebi_ad_out), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rspv", 32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(req_ready), 1);

        do_txn(1'b0, 17'h00000, 16'h0, rd);
        check("rd_dummy0", 32'(rd), 32'h0000AAAA);
        check("ale_cycles", last_ale, 2);
        check("ren_cycles", last_ren, 4);
        check("bus_cycle", last_busy, 10);
        do_txn(1'b0, 17'h00002, 16'h0, rd);
        check("rd_dummy1", 32'(rd), 32'h00005555);
        do_txn(1'b0, 17'h00010, 16'h0, rd);
        check("rd_reg10", 32'(rd), 32'h00000000);

        r0 = n_rsp;
        do_txn(1'b1, 17'h02004, 16'h1234, rd);
        check("wen_cycles", last_wen, 4);
        check("wr_keeps_rdata", 32'(rsp_rdata), 32'h00000000);
        do_txn(1'b0, 17'h02004, 16'h0, rd);
        check("rd_bram", 32'(rd), 32'h00001234);
        check("wr_rd_pulses", n_rsp - r0, 2);

        // Back-to-back: valid held high across three accepts.
        @(posedge clk); #1;
        a0 = n_acc; r0 = n_rsp;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h00002;
        n = 0;
        while (n_rsp - r0 < 3 && n < 200) begin @(posedge clk); #1; n++; end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_accepts", n_acc - a0, 3);
        check("b2b_rsps", n_rsp - r0, 3);

        // Reset during the second write strobe cycle.
        r0 = n_rsp;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h02006; req_wdata = 16'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (ebi_wen && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        check("abort_in_strobe", 32'(ebi_wen), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_wen", 32'(ebi_wen), 1);
        check("abort_csn", 32'(ebi_csn), 1);
        check("abort_oe", 32'(ebi_ad_oe), 0);
        check("abort_ren", 32'(ebi_ren), 1);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_rsp", n_rsp - r0, 0);
        do_txn(1'b0, 17'h02004, 16'h0, rd);
        check("after_abort_rd", 32'(rd), 32'h00001234);
        check("after_abort_busy", last_busy, 10);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100us");
        $fatal(1, "watchdog");
    end

endmodule
